// File: rtl/cdf_pkg.sv
// ---------------------------------------------------------------------------
// cdf_pkg
// Shared definitions for the row_loader / row_to_cdf wavelet front end.
//   LENGTH        : pixels per row (must agree with row_to_cdf)
//   DW            : pixel width in bits
//   IDX_W         : width of a pixel index within a row
//   pixel_t       : one pixel
//   row_t         : one complete row, unpacked, index 0 = first pixel received
//   issue_state_t : states of the row issue FSM
// ---------------------------------------------------------------------------
package cdf_pkg;

    localparam int LENGTH = 256;
    localparam int DW     = 8;
    localparam int IDX_W  = $clog2(LENGTH);

    typedef logic [DW-1:0] pixel_t;
    typedef pixel_t row_t [LENGTH];

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } issue_state_t;

endpackage

// File: rtl/row_bank.sv
// ---------------------------------------------------------------------------
// row_bank
// One half of the ping-pong row store: LENGTH pixels plus a full flag.
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   i_we        : write i_wdata at position i_widx this cycle
//   i_widx      : pixel position being written
//   i_wdata     : pixel value
//   i_set_full  : the write this cycle completes the row, mark the bank full
//   i_clear     : the consumer is finished with this row, mark the bank empty
//   o_full      : bank holds a complete row not yet released
//   o_data      : whole row contents
// ---------------------------------------------------------------------------
module row_bank
    import cdf_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_widx,
    input  logic [DW-1:0]    i_wdata,
    input  logic             i_set_full,
    input  logic             i_clear,
    output logic             o_full,
    output row_t             o_data
);

    row_t r_store;
    logic r_full;

    // Pixel storage and full flag. Set and clear never coincide in practice
    // (a full bank refuses writes), but set is given priority regardless.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LENGTH; i++) begin
                r_store[i] <= '0;
            end
            r_full <= 1'b0;
        end else begin
            if (i_we) begin
                r_store[i_widx] <= i_wdata;
            end
            if (i_set_full) begin
                r_full <= 1'b1;
            end else if (i_clear) begin
                r_full <= 1'b0;
            end
        end
    end

    assign o_full = r_full;
    assign o_data = r_store;

endmodule

// File: rtl/row_loader.sv
// ---------------------------------------------------------------------------
// row_loader
// Collects a valid/ready pixel stream into a two-bank row store and hands
// complete rows to row_to_cdf, one at a time, with a single-cycle start pulse.
// The next row streams into the other bank while the current one is processed.
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   s_data       : incoming pixel
//   s_valid      : s_data is valid
//   s_ready      : a pixel is accepted on this edge if s_valid is also high
//   row          : row being transformed, stable from en until after cdf_done
//   en           : one-cycle start pulse to row_to_cdf
//   cdf_done     : one-cycle completion pulse from row_to_cdf
//   busy         : a row is presented and not yet completed
//   rows_issued  : number of en pulses, wraps at 16 bits
//   err          : sticky timeout flag (always 0 without the timeout option)
// Build option:
//   ROW_LOADER_TIMEOUT_EN : abandon a presented row after TIMEOUT cycles in
//                           WAIT without cdf_done, setting err.
// ---------------------------------------------------------------------------
module row_loader
    import cdf_pkg::*;
`ifdef ROW_LOADER_TIMEOUT_EN
#(
    parameter int TIMEOUT = LENGTH + 16
)
`endif
(
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output row_t          row,
    output logic          en,
    input  logic          cdf_done,
    output logic          busy,
    output logic [15:0]   rows_issued,
    output logic          err
);

    logic             r_run;
    logic             r_fill_bank;
    logic [IDX_W-1:0] r_fill_idx;
    issue_state_t     r_state;
    logic             r_active;
    logic             r_next_issue;
    row_t             r_row;
    logic             r_en;
    logic             r_busy;
    logic [15:0]      r_rows_issued;

    logic w_accept;
    logic w_last;
    logic w_full0;
    logic w_full1;
    logic w_pending;
    logic w_release;
    logic w_timeout;
    row_t w_data0;
    row_t w_data1;

    // Ready only once out of reset and while the bank being filled is free.
    assign s_ready   = r_run && !(r_fill_bank ? w_full1 : w_full0);
    assign w_accept  = s_valid && s_ready;
    assign w_last    = w_accept && (r_fill_idx == IDX_W'(LENGTH - 1));
    // Banks fill alternately, so issuing alternately is oldest-first.
    assign w_pending = r_next_issue ? w_full1 : w_full0;
    assign w_release = (r_state == WAIT) && (cdf_done || w_timeout);

    row_bank u_bank0 (
        .clk        (clk),
        .reset      (reset),
        .i_we       (w_accept && !r_fill_bank),
        .i_widx     (r_fill_idx),
        .i_wdata    (s_data),
        .i_set_full (w_last && !r_fill_bank),
        .i_clear    (w_release && !r_active),
        .o_full     (w_full0),
        .o_data     (w_data0)
    );

    row_bank u_bank1 (
        .clk        (clk),
        .reset      (reset),
        .i_we       (w_accept && r_fill_bank),
        .i_widx     (r_fill_idx),
        .i_wdata    (s_data),
        .i_set_full (w_last && r_fill_bank),
        .i_clear    (w_release && r_active),
        .o_full     (w_full1),
        .o_data     (w_data1)
    );

`ifdef ROW_LOADER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_err;
    // cdf_done arriving on the final cycle still counts as a normal completion.
    assign w_timeout = !cdf_done && (r_wait_cnt == CNT_W'(TIMEOUT - 1));
    assign err       = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    // Fill side: step through the row positions of the current fill bank and
    // swap to the other bank as soon as the last pixel of a row lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_run       <= 1'b0;
            r_fill_bank <= 1'b0;
            r_fill_idx  <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_accept) begin
                if (w_last) begin
                    r_fill_idx  <= '0;
                    r_fill_bank <= ~r_fill_bank;
                end else begin
                    r_fill_idx <= r_fill_idx + 1'b1;
                end
            end
        end
    end

    // Issue side: latch the oldest full bank into the output row, pulse en
    // from ISSUE, then hold the row until the transform reports completion
    // (or, with the timeout option, until the wait budget runs out).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_active      <= 1'b0;
            r_next_issue  <= 1'b0;
            r_en          <= 1'b0;
            r_busy        <= 1'b0;
            r_rows_issued <= '0;
            for (int i = 0; i < LENGTH; i++) begin
                r_row[i] <= '0;
            end
`ifdef ROW_LOADER_TIMEOUT_EN
            r_wait_cnt    <= '0;
            r_err         <= 1'b0;
`endif
        end else begin
            r_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pending) begin
                        r_active     <= r_next_issue;
                        r_next_issue <= ~r_next_issue;
                        if (r_next_issue) begin
                            r_row <= w_data1;
                        end else begin
                            r_row <= w_data0;
                        end
                        r_busy  <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_en          <= 1'b1;
                    r_rows_issued <= r_rows_issued + 16'd1;
                    r_state       <= WAIT;
`ifdef ROW_LOADER_TIMEOUT_EN
                    r_wait_cnt    <= '0;
`endif
                end
                WAIT: begin
`ifdef ROW_LOADER_TIMEOUT_EN
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                    if (w_timeout) begin
                        r_err <= 1'b1;
                    end
`endif
                    if (w_release) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign row         = r_row;
    assign en          = r_en;
    assign busy        = r_busy;
    assign rows_issued = r_rows_issued;

endmodule

// File: doc/row_loader.md
Name: row_loader

Overview:
- Upstream feeder for the row_to_cdf wavelet stage.
- Accepts an 8-bit pixel stream over valid/ready and assembles LENGTH-pixel rows into a double-buffered (ping-pong) row store.
- Presents one complete row at a time on a parallel array and pulses `en` to start the transform.
- Holds that row stable until the transform reports completion, so the next row can stream in while the current one is processed.

Parameters:
- LENGTH, 256, pixels per row; must match row_to_cdf.
- DW, 8, pixel width in bits.
- TIMEOUT, LENGTH+16, max cycles to wait for cdf_done; used only with ROW_LOADER_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- s_data  in  DW  incoming pixel.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader can accept a pixel this cycle.
- row  out  LENGTH x DW  unpacked array, row to transform (index 0 = first pixel received).
- en  out  1  single-cycle start pulse to row_to_cdf.
- cdf_done  in  1  single-cycle pulse from row_to_cdf: transform of the presented row is complete.
- busy  out  1  a row is presented and awaiting cdf_done.
- rows_issued  out  16  count of en pulses; wraps at 65535 -> 0.
- err  out  1  sticky timeout flag; tied 0 without the macro.

Behaviour:
- Reset values: s_ready=0, en=0, busy=0, rows_issued=0, err=0, row=all zero, both banks empty and cleared to 0, fill index=0, fill bank=0. s_ready rises the cycle after reset deasserts.
- Handshake: a pixel is accepted on a posedge with s_valid && s_ready. It is written to fill_bank[fill_idx], then fill_idx increments.
- When fill_idx reaches LENGTH-1 and a pixel is accepted:
  - the bank is marked full;
  - fill_idx wraps to 0;
  - fill_bank toggles to the other bank.
- s_ready = 0 when the target fill bank is full; otherwise s_ready = 1 (not in reset).
- Issue FSM: IDLE -> ISSUE -> WAIT -> IDLE.
  - IDLE: if a full bank is pending, select it (oldest first) and go to ISSUE.
  - ISSUE: en=1 for exactly one cycle, busy=1, rows_issued++, then go to WAIT.
  - WAIT: busy=1. On cdf_done, mark the active bank empty and return to IDLE.
- row output: registered copy of the selected bank, loaded on IDLE->ISSUE. It is valid in the en cycle and held stable until the cycle after cdf_done, then keeps its last value.
- Latency: last pixel accepted at edge N -> en high during cycle N+2, provided the FSM is IDLE.
- Simultaneous events:
  - cdf_done in the same cycle the other bank completes filling -> FSM returns to IDLE and issues the new bank; en two cycles later.
  - cdf_done while both banks are full -> active bank freed; s_ready=1 next cycle; the other bank is issued.
- cdf_done outside WAIT is ignored.
- Reset mid-row or mid-WAIT: partial row discarded, all state returns to reset values, no en generated.
- s_data is ignored when s_ready=0; no pixel is lost or duplicated across backpressure.

Optional Feature:
- Macro: ROW_LOADER_TIMEOUT_EN.
- With the macro:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without cdf_done: err is set (sticky until reset), the active bank is freed, and the FSM returns to IDLE.
- Without the macro: no counter, WAIT lasts indefinitely, err is constant 0.

Decomposition:
- Shared package cdf_pkg:
  - LENGTH and DW constants;
  - pixel_t (logic [DW-1:0]);
  - row_t (pixel_t [LENGTH]);
  - issue_state_t enum {IDLE, ISSUE, WAIT}.
- Sub-module row_bank:
  - one LENGTH x DW store;
  - write enable, write index, full flag, clear input;
  - two instances in row_loader.

Test Plan:
- Single row: stream bytes 0..255 back-to-back, pulse cdf_done 10 cycles after en -> one en pulse 2 cycles after last accept, row[i]==i, busy high until cdf_done, rows_issued=1.
- Ping-pong: stream 3 rows (row k pixel i = (i+k)&255) with cdf_done held off 300 cycles -> s_ready drops after row 2 fills. Row 3 is accepted only after the first cdf_done; three en pulses, each row content correct in order.
- Backpressure: random s_valid gaps plus both banks full -> no dropped or duplicated pixels; the 512 pixels received match the reference sequence.
- Simultaneous: cdf_done on the same edge that row 2's last pixel is accepted -> en for row 2 exactly 2 cycles later, row equals row 2 data.
- Reset at pixel 100 of a row and during WAIT -> all outputs at reset values next cycle; the following full row issues normally with rows_issued=1.
- Timeout (macro on, TIMEOUT=272): never pulse cdf_done -> err=1 at WAIT cycle 272, bank freed, next full row issues. Macro off -> err stays 0 and busy stays 1.
